// File: rtl/seq_pkg.sv
// Shared types and helpers for the DUT vector sequencer: FSM states, default widths,
// MISR feedback taps and the result fold used by the signature register.
package seq_pkg;

   localparam int DEF_IN_W   = 150;
   localparam int DEF_OUT_W  = 80;
   localparam int DEF_CNT_W  = 16;
   localparam int FOLD_MAX_W = 256;

   // Feedback taps of x^32+x^22+x^2+x+1, seen from the shift-left register: bits 31,21,1,0.
   localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      EMIT,
      DONE
   } seq_state_t;

   // XOR of 32-bit chunks; callers zero-extend, which pads the top chunk with zeros.
   function automatic logic [31:0] fold(input logic [FOLD_MAX_W-1:0] d);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < FOLD_MAX_W / 32; k++) begin
         r = r ^ d[k*32 +: 32];
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_misr.sv
// 32-bit result signature register: clears on run start, absorbs one folded result per update.
// Updates take effect on the clock edge of the result handshake; no backpressure of its own.
module seq_misr
   import seq_pkg::*;
#(
   parameter int W = DEF_OUT_W
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          upd,
   input  logic [W-1:0]  data,
   output logic [31:0]   sig
);

   logic [FOLD_MAX_W-1:0] data_ext;
   logic                  feedback;

   assign data_ext = FOLD_MAX_W'(data);
   assign feedback = ^(sig & MISR_TAPS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig <= '0;
      end else if (clr) begin
         sig <= '0;
      end else if (upd) begin
         sig <= {sig[30:0], feedback} ^ fold(data_ext);
      end
   end

endmodule

// File: rtl/dut_vector_sequencer.sv
// Drives one vector at a time onto a combinational DUT, captures its output after SETTLE_CYCLES, one result per SETTLE_CYCLES+2 cycles;
// vec_ready only in LOAD, result held until res_ready. Build with SEQ_MISR_EN for a result signature, otherwise signature is 0.
module dut_vector_sequencer
   import seq_pkg::*;
#(
   parameter int IN_W          = DEF_IN_W,
   parameter int OUT_W         = DEF_OUT_W,
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = DEF_CNT_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  num_vectors,
   input  logic              vec_valid,
   output logic              vec_ready,
   input  logic [IN_W-1:0]   vec_data,
   output logic [IN_W-1:0]   dut_in,
   input  logic [OUT_W-1:0]  dut_out,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [OUT_W-1:0]  res_data,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  vec_count,
   output logic [31:0]       signature
);

   seq_state_t       state, state_nxt;
   logic [7:0]       settle_cnt;
   logic [CNT_W-1:0] num_lat;
   logic [CNT_W-1:0] count_inc;
   logic             start_run;
   logic             accept;
   logic             capture;
   logic             res_hs;

   assign count_inc = vec_count + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      vec_ready = 1'b0;
      done      = 1'b0;
      start_run = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      res_hs    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (num_vectors != '0) begin
                  start_run = 1'b1;
                  state_nxt = LOAD;
               end else begin
                  state_nxt = DONE;
               end
            end
         end
         LOAD: begin
            vec_ready = 1'b1;
            if (vec_valid) begin
               accept    = 1'b1;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt <= 8'd1) begin
               capture   = 1'b1;
               state_nxt = EMIT;
            end
         end
         EMIT: begin
            if (res_ready) begin
               res_hs    = 1'b1;
               state_nxt = (count_inc == num_lat) ? DONE : LOAD;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Abort wins over any handshake seen in the same cycle.
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
         accept    = 1'b0;
         capture   = 1'b0;
         res_hs    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dut_in     <= '0;
         res_data   <= '0;
         res_valid  <= 1'b0;
         busy       <= 1'b0;
         vec_count  <= '0;
         num_lat    <= '0;
         settle_cnt <= '0;
      end else begin
         if (start_run) begin
            num_lat   <= num_vectors;
            vec_count <= '0;
            busy      <= 1'b1;
         end
         if (accept) begin
            dut_in     <= vec_data;
            settle_cnt <= 8'(SETTLE_CYCLES);
         end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt - 8'd1;
         end
         if (capture) begin
            res_data  <= dut_out;
            res_valid <= 1'b1;
         end
         if (res_hs) begin
            res_valid <= 1'b0;
            vec_count <= count_inc;
         end
         if (state == DONE) begin
            busy <= 1'b0;
         end
         if (abort && (state != IDLE)) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
         end
      end
   end

`ifdef SEQ_MISR_EN
   seq_misr #(
      .W (OUT_W)
   ) u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_run),
      .upd   (res_hs),
      .data  (res_data),
      .sig   (signature)
   );
`else
   assign signature = '0;
`endif

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Bench for dut_vector_sequencer: two instances (settle 1 and 4) driving a stand-in combinational DUT,
// directed scenarios plus a random phase, all outputs compared each cycle against a transaction-level model.
module tb_dut_vector_sequencer;

   logic clk;
   logic rst_n;

   logic         start       [2];
   logic         abort       [2];
   logic [15:0]  num_vectors [2];
   logic         vec_valid   [2];
   logic         vec_ready   [2];
   logic [149:0] vec_data    [2];
   logic [149:0] dut_in      [2];
   logic [79:0]  dut_out     [2];
   logic         res_valid   [2];
   logic         res_ready   [2];
   logic [79:0]  res_data    [2];
   logic         busy        [2];
   logic         done        [2];
   logic [15:0]  vec_count   [2];
   logic [31:0]  signature   [2];

   int checks = 0;
   int errors = 0;

   int n_done  [2];
   int n_res   [2];
   int n_ready [2];
   int n_rv    [2];

   // Stand-in for the real combinational datapath.
   function automatic logic [79:0] stand_in(input logic [149:0] x);
      logic [79:0] y;
      y = x[79:0];
      y[79] = y[79] ^ x[100];
      y[11] = y[11] ^ x[100];
      y[9]  = y[9] ^ x[100];
      y[2]  = y[2] ^ (x[51] & x[13]);
      y[40 +: 30] = y[40 +: 30] ^ x[120 +: 30];
      return y;
   endfunction

   function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [79:0] d);
      logic [31:0] f;
      f = '0;
      for (int b = 0; b < 80; b++) f[b % 32] = f[b % 32] ^ d[b];
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ f;
   endfunction

   function automatic logic [149:0] rand_vec();
      logic [159:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom};
      return t[149:0];
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int S = (g == 0) ? 1 : 4;
      dut_vector_sequencer #(
         .IN_W          (150),
         .OUT_W         (80),
         .SETTLE_CYCLES (S),
         .CNT_W         (16)
      ) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .start       (start[g]),
         .abort       (abort[g]),
         .num_vectors (num_vectors[g]),
         .vec_valid   (vec_valid[g]),
         .vec_ready   (vec_ready[g]),
         .vec_data    (vec_data[g]),
         .dut_in      (dut_in[g]),
         .dut_out     (dut_out[g]),
         .res_valid   (res_valid[g]),
         .res_ready   (res_ready[g]),
         .res_data    (res_data[g]),
         .busy        (busy[g]),
         .done        (done[g]),
         .vec_count   (vec_count[g]),
         .signature   (signature[g])
      );
      assign dut_out[g] = stand_in(dut_in[g]);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction-level reference: what each instance must show after every edge.
   logic         e_ready  [2];
   logic         e_rv     [2];
   logic [79:0]  e_rdata  [2];
   logic         e_busy   [2];
   logic         e_done   [2];
   logic [15:0]  e_count  [2];
   logic [15:0]  e_target [2];
   logic [149:0] e_din    [2];
   logic [31:0]  e_sig    [2];
   int           e_wait   [2];

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            e_ready[i] = 0; e_rv[i] = 0; e_rdata[i] = '0; e_busy[i] = 0; e_done[i] = 0;
            e_count[i] = '0; e_target[i] = '0; e_din[i] = '0; e_sig[i] = '0; e_wait[i] = 0;
         end else if (e_done[i]) begin
            e_done[i] = 0;
            e_busy[i] = 0;
         end else if (!e_busy[i]) begin
            if (start[i]) begin
               if (num_vectors[i] != 0) begin
                  e_busy[i] = 1; e_target[i] = num_vectors[i]; e_count[i] = 0;
                  e_sig[i] = 0; e_ready[i] = 1;
               end else begin
                  e_done[i] = 1;
               end
            end
         end else if (abort[i]) begin
            e_busy[i] = 0; e_ready[i] = 0; e_rv[i] = 0; e_wait[i] = 0;
         end else if (e_ready[i]) begin
            if (vec_valid[i]) begin
               e_din[i] = vec_data[i];
               e_ready[i] = 0;
               e_wait[i] = (i == 0) ? 1 : 4;
            end
         end else if (e_wait[i] > 0) begin
            e_wait[i] = e_wait[i] - 1;
            if (e_wait[i] == 0) begin
               e_rv[i] = 1;
               e_rdata[i] = stand_in(e_din[i]);
            end
         end else if (e_rv[i] && res_ready[i]) begin
            e_rv[i] = 0;
            e_sig[i] = misr_step(e_sig[i], e_rdata[i]);
            e_count[i] = e_count[i] + 16'd1;
            if (e_count[i] == e_target[i]) e_done[i] = 1;
            else e_ready[i] = 1;
         end
      end
   end

   task automatic chk(input string nm, input int i, input logic [149:0] act, input logic [149:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %h expected %h at %0t", nm, i, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [31:0] exp_sig;
`ifdef SEQ_MISR_EN
         exp_sig = e_sig[i];
`else
         exp_sig = '0;
`endif
         chk("vec_ready", i, 150'(vec_ready[i]), 150'(e_ready[i]));
         chk("res_valid", i, 150'(res_valid[i]), 150'(e_rv[i]));
         chk("res_data",  i, 150'(res_data[i]),  150'(e_rdata[i]));
         chk("busy",      i, 150'(busy[i]),      150'(e_busy[i]));
         chk("done",      i, 150'(done[i]),      150'(e_done[i]));
         chk("vec_count", i, 150'(vec_count[i]), 150'(e_count[i]));
         chk("dut_in",    i, dut_in[i],          e_din[i]);
         chk("signature", i, 150'(signature[i]), 150'(exp_sig));
         if (done[i]) n_done[i]++;
         if (res_valid[i] && res_ready[i] && !abort[i]) n_res[i]++;
         if (vec_ready[i]) n_ready[i]++;
         if (res_valid[i]) n_rv[i]++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sel(input int i, input int which);
      case (which)
         0:       return res_valid[i];
         1:       return done[i];
         default: return vec_ready[i];
      endcase
   endfunction

   task automatic wait_for(input int i, input int which, input int budget, output int cyc);
      cyc = 0;
      while (!sel(i, which) && cyc < budget) begin
         step();
         cyc++;
      end
      if (!sel(i, which)) begin
         checks++;
         errors++;
         $display("FAIL timeout waiting for event %0d on instance %0d", which, i);
      end
   endtask

   task automatic pulse_start(input int i, input logic [15:0] n);
      start[i] = 1'b1;
      num_vectors[i] = n;
      step();
      start[i] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, c2, nd, nr, nrdy, nrv;
      logic [149:0] v;
      for (int i = 0; i < 2; i++) begin
         start[i] = 0; abort[i] = 0; num_vectors[i] = '0; vec_valid[i] = 0;
         vec_data[i] = '0; res_ready[i] = 0;
         n_done[i] = 0; n_res[i] = 0; n_ready[i] = 0; n_rv[i] = 0;
      end
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_busy",  0, 150'(busy[0]), 150'(0));
      chk("rst_rv",    1, 150'(res_valid[1]), 150'(0));
      chk("rst_dutin", 0, dut_in[0], 150'(0));
      rst_n = 1'b1;
      step();

      // Single vector, bit 100 only, settle 1.
      pulse_start(0, 16'd1);
      v = '0; v[100] = 1'b1;
      vec_data[0] = v; vec_valid[0] = 1; res_ready[0] = 1;
      step();
      vec_valid[0] = 0;
      wait_for(0, 0, 10, c);
      chk("lat_res", 0, 150'(c), 150'(1));
      chk("bit79",   0, 150'(res_data[0][79]), 150'(1));
      chk("bits11_7", 0, 150'(res_data[0][11:7]), 150'(5'b10100));
      chk("bit70",   0, 150'(res_data[0][70]), 150'(0));
      wait_for(0, 1, 10, c2);
      chk("lat_done", 0, 150'(c + c2), 150'(2));
      chk("count1",  0, 150'(vec_count[0]), 150'(1));
      res_ready[0] = 0;
      step();

      // Three vectors with four stall cycles per result.
      nd = n_done[0]; nr = n_res[0];
      pulse_start(0, 16'd3);
      for (int k = 0; k < 3; k++) begin
         v = rand_vec();
         vec_data[0] = v; vec_valid[0] = 1;
         wait_for(0, 2, 10, c);
         step();
         vec_valid[0] = 0;
         wait_for(0, 0, 10, c);
         repeat (4) begin
            step();
            chk("stall_data", 0, 150'(res_data[0]), 150'(stand_in(v)));
         end
         res_ready[0] = 1;
         step();
         res_ready[0] = 0;
      end
      wait_for(0, 1, 10, c);
      step();
      chk("bp_done_cnt", 0, 150'(n_done[0] - nd), 150'(1));
      chk("bp_res_cnt",  0, 150'(n_res[0] - nr), 150'(3));

      // Zero-length run.
      nd = n_done[0]; nrdy = n_ready[0];
      pulse_start(0, 16'd0);
      chk("zero_done", 0, 150'(done[0]), 150'(1));
      chk("zero_busy", 0, 150'(busy[0]), 150'(0));
      step();
      chk("zero_done_off", 0, 150'(done[0]), 150'(0));
      step();
      chk("zero_rdy_cnt",  0, 150'(n_ready[0] - nrdy), 150'(0));
      chk("zero_done_cnt", 0, 150'(n_done[0] - nd), 150'(1));

      // Abort during settle on the settle-4 instance, then a clean restart.
      nd = n_done[1]; nrv = n_rv[1];
      pulse_start(1, 16'd2);
      vec_data[1] = rand_vec(); vec_valid[1] = 1;
      step();
      vec_valid[1] = 0;
      step(); step();
      abort[1] = 1;
      step();
      abort[1] = 0;
      chk("ab_busy",  1, 150'(busy[1]), 150'(0));
      chk("ab_rdy",   1, 150'(vec_ready[1]), 150'(0));
      chk("ab_count", 1, 150'(vec_count[1]), 150'(0));
      repeat (6) step();
      chk("ab_no_done", 1, 150'(n_done[1] - nd), 150'(0));
      chk("ab_no_rv",   1, 150'(n_rv[1] - nrv), 150'(0));
      pulse_start(1, 16'd2);
      vec_data[1] = rand_vec(); vec_valid[1] = 1; res_ready[1] = 1;
      step();
      wait_for(1, 0, 20, c);
      chk("lat_res4", 1, 150'(c), 150'(4));
      wait_for(1, 1, 40, c);
      chk("restart_count", 1, 150'(vec_count[1]), 150'(2));
      vec_valid[1] = 0; res_ready[1] = 0;
      step();

      // Asynchronous reset while a result is held.
      pulse_start(0, 16'd2);
      vec_data[0] = rand_vec(); vec_valid[0] = 1;
      step();
      vec_valid[0] = 0;
      wait_for(0, 0, 10, c);
      #3;
      rst_n = 1'b0;
      #1;
      chk("ar_rv",    0, 150'(res_valid[0]), 150'(0));
      chk("ar_busy",  0, 150'(busy[0]), 150'(0));
      chk("ar_count", 0, 150'(vec_count[0]), 150'(0));
      chk("ar_rdata", 0, 150'(res_data[0]), 150'(0));
      chk("ar_dutin", 0, dut_in[0], 150'(0));
      chk("ar_sig",   0, 150'(signature[0]), 150'(0));
      step();
      rst_n = 1'b1;
      step();

      // Start while busy is ignored.
      nr = n_res[0];
      pulse_start(0, 16'd2);
      start[0] = 1; num_vectors[0] = 16'd5;
      step();
      start[0] = 0; num_vectors[0] = '0;
      vec_data[0] = rand_vec(); vec_valid[0] = 1; res_ready[0] = 1;
      wait_for(0, 1, 30, c);
      chk("sb_count", 0, 150'(vec_count[0]), 150'(2));
      step();
      chk("sb_res_cnt", 0, 150'(n_res[0] - nr), 150'(2));
      vec_valid[0] = 0; res_ready[0] = 0;

      // Signature over two results with bits 51 and 13 set.
      pulse_start(0, 16'd2);
      v = '0; v[51] = 1'b1; v[13] = 1'b1;
      vec_data[0] = v; vec_valid[0] = 1; res_ready[0] = 1;
      wait_for(0, 1, 20, c);
`ifdef SEQ_MISR_EN
      chk("sig_literal", 0, 150'(signature[0]), 150'(32'h0018_600C));
`else
      chk("sig_literal", 0, 150'(signature[0]), 150'(0));
`endif
      vec_valid[0] = 0; res_ready[0] = 0;
      step();

      // Random phase on both instances.
      repeat (1500) begin
         for (int i = 0; i < 2; i++) begin
            start[i]       = ($urandom_range(0, 9) == 0);
            num_vectors[i] = 16'($urandom_range(0, 4));
            vec_valid[i]   = ($urandom_range(0, 9) < 7);
            vec_data[i]    = rand_vec();
            res_ready[i]   = ($urandom_range(0, 9) < 6);
            abort[i]       = ($urandom_range(0, 39) == 0);
         end
         step();
      end
      for (int i = 0; i < 2; i++) begin
         start[i] = 0; vec_valid[i] = 0; res_ready[i] = 0; abort[i] = 1;
      end
      step();
      for (int i = 0; i < 2; i++) abort[i] = 0;
      repeat (5) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
